// File: rtl/fpio_fifo_push_arb_if.sv
// Push-side bundle between producers, the push arbiter and one fpio_fifo fifo_in port.
// master: arbiter view; slave: producer/FIFO environment view.
interface fpio_fifo_push_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_BITS  = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic                          fifo_data_en;
  logic                          fifo_data_ack;
  logic [FIFO_BITS:0]            fifo_avail;

  modport master (
    input  req_valid, req_data, fifo_data_ack, fifo_avail,
    output req_ack, fifo_data, fifo_data_en
  );

  modport slave (
    output req_valid, req_data, fifo_data_ack, fifo_avail,
    input  req_ack, fifo_data, fifo_data_en
  );
endinterface

// File: rtl/fpio_fifo_push_arb.sv
// Round-robin arbiter sharing one fpio_fifo push port among NUM_REQ producers.
// Each push is grant -> one-cycle data_en -> wait for data_ack (or time out).
module fpio_fifo_push_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_BITS   = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  fpio_fifo_push_arb_if.master       bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [31:0]                push_count
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int IDX_W = ID_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PUSH = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       winner;
  logic                  found;
  logic [IDX_W-1:0]      scan_idx;
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  logic [DATA_WIDTH-1:0] win_data;
  logic [7:0]            timer;
  logic [FIFO_BITS:0]    avail;

  assign avail = bus.fifo_avail;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_word[k] = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan starts at rr_ptr and wraps; one extra index bit keeps the sum in range
  // for non power-of-two NUM_REQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + IDX_W'(k);
      if (scan_idx >= IDX_W'(NUM_REQ)) scan_idx = scan_idx - IDX_W'(NUM_REQ);
      if (!found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  assign win_data = req_word[winner];

  assign bus.fifo_data_en = (state == ST_PUSH);
  assign busy             = (state != ST_IDLE);

  always_comb begin
    bus.req_ack = '0;
    if (state == ST_WAIT && bus.fifo_data_ack) bus.req_ack[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      bus.fifo_data <= '0;
      timeout_err   <= 1'b0;
      push_count    <= '0;
      timer         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found && avail != '0) begin
            grant_id      <= winner;
            bus.fifo_data <= win_data;
            rr_ptr        <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            state         <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.fifo_data_ack) begin
            push_count <= push_count + 32'd1;
            state      <= ST_IDLE;
          end else if (timer == 8'(ACK_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpio_fifo_push_arb.sv
// Self-checking bench for fpio_fifo_push_arb: FIFO/producer model, directed
// sequences, an arbitration vector table and a randomized run.
module tb_fpio_fifo_push_arb;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int FB = 4;
  localparam int AW = FB + 1;
  localparam int AT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [31:0] push_count;

  fpio_fifo_push_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_BITS(FB)) bus ();

  fpio_fifo_push_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_BITS(FB), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err), .push_count(push_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    int         win;
  } vec_t;

  vec_t        tbl [10];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  v_valid;
  logic [31:0] v_data [NR];
  bit          v_rst;
  bit          ack_on;
  bit          auto_drop;
  int          cap;
  logic [31:0] q [$];
  bit          ack_pending;
  logic [31:0] pend_word;
  int          mptr;
  int          mwin;
  int          m_cnt;
  bit          prev_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input int p, input logic [3:0] v);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  task automatic drive();
    rst = v_rst;
    bus.req_valid = v_valid;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = v_data[i];
  endtask

  // One clock: FIFO model answers, transaction-level model checks the DUT.
  task automatic tick();
    logic [3:0] e_valid;
    int         e_avail;
    bit         e_rst, e_idle, acked;
    logic [3:0] exp_ack;
    e_valid = v_valid;
    e_avail = int'(bus.fifo_avail);
    e_rst   = v_rst;
    e_idle  = !prev_busy;
    @(posedge clk);
    #1;
    acked = ack_pending && ack_on && !e_rst;
    ack_pending = 0;
    bus.fifo_data_ack = acked;
    if (acked) q.push_back(pend_word);
    if (e_rst) begin
      mptr  = 0;
      m_cnt = 0;
    end else begin
      chk("data_en", bus.fifo_data_en, e_idle && e_valid != 0 && e_avail != 0);
      if (bus.fifo_data_en) begin
        mwin = rr(mptr, e_valid);
        mptr = (mwin + 1) % NR;
        chk("grant_id", grant_id, mwin);
        chk("fifo_data", bus.fifo_data, v_data[mwin]);
        ack_pending = 1;
        pend_word = bus.fifo_data;
      end
    end
    bus.fifo_avail = AW'(cap - q.size());
    #1;
    exp_ack = acked ? (4'b0001 << mwin) : 4'b0000;
    chk("req_ack", bus.req_ack, exp_ack);
    chk("push_count", push_count, m_cnt);
    if (acked) begin
      m_cnt++;
      if (auto_drop) v_valid[mwin] = 1'b0;
    end
    prev_busy = busy;
    drive();
  endtask

  task automatic wait_en(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      seen = bus.fifo_data_en;
    end
  endtask

  task automatic do_reset();
    v_rst = 1; v_valid = '0; ack_on = 1; auto_drop = 1; cap = 16;
    q.delete(); ack_pending = 0;
    drive();
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_data_en", bus.fifo_data_en, 0);
    chk("rst_fifo_data", bus.fifo_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ack", bus.req_ack, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_push_count", push_count, 0);
    v_rst = 0;
    drive();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int bad, cnt;
    for (int i = 0; i < NR; i++) v_data[i] = '0;
    v_valid = '0; v_rst = 1; ack_on = 1; auto_drop = 1; cap = 16;
    bus.fifo_data_ack = 1'b0;
    bus.fifo_avail = AW'(16);
    prev_busy = 0; mptr = 0; mwin = 0; m_cnt = 0; ack_pending = 0; pend_word = '0;
    drive();

    tbl[0] = '{4'b0001, 0}; tbl[1] = '{4'b0001, 0}; tbl[2] = '{4'b1111, 1};
    tbl[3] = '{4'b1111, 2}; tbl[4] = '{4'b0011, 0}; tbl[5] = '{4'b1000, 3};
    tbl[6] = '{4'b0110, 1}; tbl[7] = '{4'b1001, 3}; tbl[8] = '{4'b0100, 2};
    tbl[9] = '{4'b0111, 0};

    // Single push, nominal three-cycle timing
    do_reset();
    v_data[0] = 32'hA5A5_A5A5; v_valid = 4'b0001; drive();
    tick();
    chk("t1_data_en", bus.fifo_data_en, 1);
    chk("t1_fifo_data", bus.fifo_data, 32'hA5A5_A5A5);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_req_ack", bus.req_ack, 4'b0001);
    chk("t1_data_en_low", bus.fifo_data_en, 0);
    tick();
    chk("t1_push_count", push_count, 1);
    chk("t1_idle", busy, 0);

    // Arbitration vector table, pointer carried from entry to entry
    do_reset();
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NR; i++) v_data[i] = 32'hD000_0000 + 32'(i * 256 + t);
      v_valid = tbl[t].valid; drive();
      wait_en(6, seen);
      chk("tbl_en_seen", seen, 1);
      chk("tbl_grant", grant_id, tbl[t].win);
      chk("tbl_data", bus.fifo_data, 32'hD000_0000 + 32'(tbl[t].win * 256 + t));
      tick();
      chk("tbl_req_ack", bus.req_ack, 4'b0001 << tbl[t].win);
      v_valid = '0; drive();
      tick();
    end

    // All requesters held: strict rotation
    do_reset();
    auto_drop = 0; v_valid = 4'b1111; drive();
    for (int p = 0; p < 12; p++) begin
      wait_en(6, seen);
      chk("t2_en_seen", seen, 1);
      chk("t2_rr_order", grant_id, p % NR);
    end
    tick();
    tick();
    chk("t2_push_count", push_count, 12);
    v_valid = '0; drive();
    tick();
    tick();

    // Zero space blocks grants; one free entry allows exactly one push
    do_reset();
    auto_drop = 0; cap = 0; tick();
    v_valid = 4'b0010; v_data[1] = 32'h1111_2222; drive();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.fifo_data_en || busy) bad++;
    end
    chk("t3_blocked", bad, 0);
    cap = 1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.fifo_data_en) cnt++;
    end
    chk("t3_one_push", cnt, 1);
    chk("t3_fifo_level", q.size(), 1);

    // Four-entry FIFO fills, then one pop releases exactly one more push
    do_reset();
    auto_drop = 0; cap = 4; v_valid = 4'b1111; drive();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.fifo_data_en) cnt++;
    end
    chk("t4_fill_pushes", cnt, 4);
    void'(q.pop_front());
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.fifo_data_en) cnt++;
    end
    chk("t4_after_pop", cnt, 1);
    chk("t4_push_count", push_count, 5);

    // Ack withheld: abort after AT cycles in WAIT, error is sticky
    do_reset();
    ack_on = 0; v_data[0] = 32'h5555_AAAA; v_valid = 4'b0001; drive();
    wait_en(6, seen);
    chk("t5_en_seen", seen, 1);
    bad = 0;
    for (int c = 0; c < AT; c++) begin
      tick();
      if (busy !== 1'b1 || timeout_err !== 1'b0 || bus.req_ack !== 4'b0000) bad++;
    end
    chk("t5_wait_window", bad, 0);
    tick();
    chk("t5_timeout_err", timeout_err, 1);
    chk("t5_idle", busy, 0);
    chk("t5_no_count", push_count, 0);
    ack_on = 1;
    wait_en(6, seen);
    chk("t5_retry_en_seen", seen, 1);
    tick();
    chk("t5_retry_req_ack", bus.req_ack, 4'b0001);
    tick();
    chk("t5_err_sticky", timeout_err, 1);
    chk("t5_retry_count", push_count, 1);

    // Reset during WAIT aborts the push and returns the pointer to 0
    do_reset();
    ack_on = 0; v_data[1] = 32'h0BAD_F00D; v_valid = 4'b0010; drive();
    wait_en(6, seen);
    chk("t6_en_seen", seen, 1);
    chk("t6_grant1", grant_id, 1);
    tick();
    v_rst = 1; drive();
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_data_en", bus.fifo_data_en, 0);
    chk("t6_fifo_data", bus.fifo_data, 0);
    chk("t6_grant_id", grant_id, 0);
    chk("t6_req_ack", bus.req_ack, 0);
    chk("t6_push_count", push_count, 0);
    v_rst = 0; ack_on = 1; v_valid = 4'b1111; drive();
    wait_en(6, seen);
    chk("t6_en_seen2", seen, 1);
    chk("t6_ptr_reset", grant_id, 0);
    v_valid = '0; drive();
    tick();
    tick();

    // Randomized traffic with random FIFO drain
    do_reset();
    cap = 6;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v_valid[i] && $urandom_range(0, 3) == 0) begin
          v_valid[i] = 1'b1;
          v_data[i] = $urandom;
        end
      end
      if (q.size() != 0 && $urandom_range(0, 2) == 0) void'(q.pop_front());
      drive();
      tick();
      if (q.size() > cap) chk("rand_fifo_overflow", q.size(), cap);
    end
    v_valid = '0; drive();
    for (int c = 0; c < 4; c++) tick();
    chk("rand_activity", m_cnt > 100, 1);
    chk("rand_timeout_clear", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
